// File: rtl/raster_pkg.sv
// raster_pkg: shared constants and types for the raster engine.
//   COORD_W      coordinate width (framebuffer is FB_DIM x FB_DIM)
//   ERR_W        signed width of the Bresenham error terms
//   CMD_*        command opcodes
//   state_e      engine FSM state encoding
//   clip_extent  origin + extent, saturated at the last column/row
package raster_pkg;

  localparam int unsigned COORD_W = 3;
  localparam int unsigned FB_DIM  = 1 << COORD_W;
  localparam int unsigned ERR_W   = 6;

  localparam logic [1:0] CMD_CLEAR = 2'b00;
  localparam logic [1:0] CMD_PIXEL = 2'b01;
  localparam logic [1:0] CMD_LINE  = 2'b10;
  localparam logic [1:0] CMD_RECT  = 2'b11;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StClear = 3'd1,
    StPixel = 3'd2,
    StLine  = 3'd3,
    StRect  = 3'd4
  } state_e;

  // Sum is formed one bit wider so an overflowing rectangle clips instead of wrapping.
  function automatic logic [COORD_W-1:0] clip_extent(input logic [COORD_W-1:0] origin,
                                                     input logic [COORD_W-1:0] extent);
    logic [COORD_W:0] sum;
    sum = {1'b0, origin} + {1'b0, extent};
    if (sum > (COORD_W+1)'(FB_DIM - 1)) begin
      return COORD_W'(FB_DIM - 1);
    end
    return sum[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/raster_engine_if.sv
// raster_engine_if: command, status and row-read signals of the raster engine.
//   command/x1/y1/x2/y2/rect_width/rect_height/command_valid : decoded command in
//   busy/done/cmd_dropped                                     : status out
//   rd_row / rd_data                                          : combinational row read
// modport master drives commands (decoder/display side); slave is the engine.
interface raster_engine_if;
  import raster_pkg::*;

  logic [1:0]         command;
  logic [COORD_W-1:0] x1;
  logic [COORD_W-1:0] y1;
  logic [COORD_W-1:0] x2;
  logic [COORD_W-1:0] y2;
  logic [COORD_W-1:0] rect_width;
  logic [COORD_W-1:0] rect_height;
  logic               command_valid;
  logic               busy;
  logic               done;
  logic               cmd_dropped;
  logic [COORD_W-1:0] rd_row;
  logic [FB_DIM-1:0]  rd_data;

  modport master (
    output command, x1, y1, x2, y2, rect_width, rect_height, command_valid, rd_row,
    input  busy, done, cmd_dropped, rd_data
  );

  modport slave (
    input  command, x1, y1, x2, y2, rect_width, rect_height, command_valid, rd_row,
    output busy, done, cmd_dropped, rd_data
  );

endinterface

// File: rtl/raster_line_stepper.sv
// raster_line_stepper: Bresenham point generator, one point per step.
//   clk, rst_n          clock, async active-low reset
//   load                latch start/end points and initialise error terms
//   step                advance to the next point on the line
//   x_start/y_start     first point (inclusive)
//   x_end/y_end         last point (inclusive)
//   x, y                current point
//   last                current point is the end point
module raster_line_stepper
  import raster_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [COORD_W-1:0] x_start,
  input  logic [COORD_W-1:0] y_start,
  input  logic [COORD_W-1:0] x_end,
  input  logic [COORD_W-1:0] y_end,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last
);

  logic [COORD_W-1:0]      x_q, x_d, y_q, y_d, xe_q, xe_d, ye_q, ye_d;
  logic                    sx_q, sx_d, sy_q, sy_d;  // 1 = increment
  logic signed [ERR_W-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;

  logic [COORD_W-1:0]      adx, ady;
  logic signed [ERR_W-1:0] e2, add_x, add_y;
  logic                    move_x, move_y;

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    xe_d  = xe_q;
    ye_d  = ye_q;
    sx_d  = sx_q;
    sy_d  = sy_q;
    dx_d  = dx_q;
    dy_d  = dy_q;
    err_d = err_q;

    adx    = (x_end >= x_start) ? (x_end - x_start) : (x_start - x_end);
    ady    = (y_end >= y_start) ? (y_end - y_start) : (y_start - y_end);
    e2     = err_q <<< 1;
    move_x = (e2 >= dy_q);
    move_y = (e2 <= dx_q);
    add_x  = move_x ? dy_q : '0;
    add_y  = move_y ? dx_q : '0;

    if (load) begin
      x_d   = x_start;
      y_d   = y_start;
      xe_d  = x_end;
      ye_d  = y_end;
      sx_d  = (x_end >= x_start);
      sy_d  = (y_end >= y_start);
      dx_d  = $signed(ERR_W'(adx));
      dy_d  = -$signed(ERR_W'(ady));
      err_d = dx_d + dy_d;
    end else if (step) begin
      err_d = err_q + add_x + add_y;
      if (move_x) begin
        x_d = sx_q ? (x_q + 1'b1) : (x_q - 1'b1);
      end
      if (move_y) begin
        y_d = sy_q ? (y_q + 1'b1) : (y_q - 1'b1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      y_q   <= '0;
      xe_q  <= '0;
      ye_q  <= '0;
      sx_q  <= 1'b0;
      sy_q  <= 1'b0;
      dx_q  <= '0;
      dy_q  <= '0;
      err_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      xe_q  <= xe_d;
      ye_q  <= ye_d;
      sx_q  <= sx_d;
      sy_q  <= sy_d;
      dx_q  <= dx_d;
      dy_q  <= dy_d;
      err_q <= err_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = (x_q == xe_q) && (y_q == ye_q);

endmodule

// File: rtl/raster_engine.sv
// raster_engine: rasterises CLEAR/PIXEL/LINE/RECT commands into an 8x8 one-bit
// framebuffer at one pixel per clock.
//   clk, rst_n  clock, async active-low reset (aborts command, clears framebuffer)
//   bus         raster_engine_if.slave: command in, busy/done/cmd_dropped out,
//               combinational row read (rd_row -> rd_data, bit x = pixel (x, rd_row))
// Build option: define RASTER_XOR_MODE_EN to make PIXEL/LINE/RECT toggle pixels
// instead of setting them (CLEAR always zeroes).
module raster_engine
  import raster_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  raster_engine_if.slave  bus
);

  state_e             state_q, state_d;
  logic               busy_q;
  logic               done_q, done_d;
  logic               dropped_q, dropped_d;
  logic [COORD_W-1:0] x1_q, x1_d, y1_q, y1_d;
  logic [COORD_W-1:0] xe_q, xe_d, ye_q, ye_d;  // inclusive RECT corner after clipping
  logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;  // RECT scan position

  logic [FB_DIM-1:0][FB_DIM-1:0] fb_q, fb_d;  // fb_q[y][x]

  logic               line_load, line_step, line_last;
  logic [COORD_W-1:0] line_x, line_y;

  logic               wr_en, clr;
  logic [COORD_W-1:0] wr_x, wr_y;

  raster_line_stepper u_line_stepper (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (line_load),
    .step    (line_step),
    .x_start (bus.x1),
    .y_start (bus.y1),
    .x_end   (bus.x2),
    .y_end   (bus.y2),
    .x       (line_x),
    .y       (line_y),
    .last    (line_last)
  );

  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    dropped_d = dropped_q | (bus.command_valid && (state_q != StIdle));
    x1_d      = x1_q;
    y1_d      = y1_q;
    xe_d      = xe_q;
    ye_d      = ye_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    line_load = 1'b0;
    line_step = 1'b0;
    wr_en     = 1'b0;
    clr       = 1'b0;
    wr_x      = '0;
    wr_y      = '0;

    unique case (state_q)
      StIdle: begin
        // Done cycle is already StIdle, so a command here gives back-to-back throughput.
        if (bus.command_valid) begin
          x1_d      = bus.x1;
          y1_d      = bus.y1;
          xe_d      = clip_extent(bus.x1, bus.rect_width);
          ye_d      = clip_extent(bus.y1, bus.rect_height);
          cx_d      = bus.x1;
          cy_d      = bus.y1;
          line_load = (bus.command == CMD_LINE);
          case (bus.command)
            CMD_CLEAR: state_d = StClear;
            CMD_PIXEL: state_d = StPixel;
            CMD_LINE:  state_d = StLine;
            default:   state_d = StRect;
          endcase
        end
      end
      StClear: begin
        clr     = 1'b1;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      StPixel: begin
        wr_en   = 1'b1;
        wr_x    = x1_q;
        wr_y    = y1_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      StLine: begin
        wr_en = 1'b1;
        wr_x  = line_x;
        wr_y  = line_y;
        if (line_last) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          line_step = 1'b1;
        end
      end
      StRect: begin
        wr_en = 1'b1;
        wr_x  = cx_q;
        wr_y  = cy_q;
        if (cx_q == xe_q) begin
          if (cy_q == ye_q) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            cx_d = x1_q;
            cy_d = cy_q + 1'b1;
          end
        end else begin
          cx_d = cx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    fb_d = fb_q;
    if (clr) begin
      fb_d = '0;
    end else if (wr_en) begin
`ifdef RASTER_XOR_MODE_EN
      fb_d[wr_y][wr_x] = ~fb_q[wr_y][wr_x];
`else
      fb_d[wr_y][wr_x] = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dropped_q <= 1'b0;
      x1_q      <= '0;
      y1_q      <= '0;
      xe_q      <= '0;
      ye_q      <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      fb_q      <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= (state_d != StIdle);
      done_q    <= done_d;
      dropped_q <= dropped_d;
      x1_q      <= x1_d;
      y1_q      <= y1_d;
      xe_q      <= xe_d;
      ye_q      <= ye_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      fb_q      <= fb_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.cmd_dropped = dropped_q;
  assign bus.rd_data     = fb_q[bus.rd_row];

endmodule

// File: tb/tb_raster_engine.sv
// tb_raster_engine: directed, table-driven bench for raster_engine.
`timescale 1ns/100ps
module tb_raster_engine;
  import raster_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  raster_engine_if bus ();

  raster_engine u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]      cmd;
    logic [2:0]      x1;
    logic [2:0]      y1;
    logic [2:0]      x2;
    logic [2:0]      y2;
    logic [2:0]      w;
    logic [2:0]      h;
    int              edges;  // accept edge counts as 1
    logic [7:0][7:0] rows;   // rows[y]
  } vec_t;

  vec_t vecs[7];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drives one command; returns #1 after its accept edge.
  task automatic issue(input logic [1:0] cmd, input logic [2:0] ax1, input logic [2:0] ay1,
                       input logic [2:0] ax2, input logic [2:0] ay2, input logic [2:0] aw,
                       input logic [2:0] ah);
    bus.command       = cmd;
    bus.x1            = ax1;
    bus.y1            = ay1;
    bus.x2            = ax2;
    bus.y2            = ay2;
    bus.rect_width    = aw;
    bus.rect_height   = ah;
    bus.command_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.command_valid = 1'b0;
  endtask

  // Counts edges (accept = 1) until done; pulses command_valid on edge inject_at.
  task automatic wait_done(input int inject_at, output int edges);
    int  n;
    logic got;
    n   = 1;
    got = 1'b0;
    while (!got && n < 300) begin
      if (n + 1 == inject_at) begin
        bus.command       = CMD_PIXEL;
        bus.x1            = 3'd0;
        bus.y1            = 3'd0;
        bus.command_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      bus.command_valid = 1'b0;
      n++;
      got = bus.done;
    end
    edges = got ? n : -1;
  endtask

  task automatic check_rows(input string tag, input logic [7:0][7:0] exp);
    for (int r = 0; r < 8; r++) begin
      bus.rd_row = 3'(r);
      #0.2;
      check($sformatf("%s_row%0d", tag, r), 64'(bus.rd_data), 64'(exp[r]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int              e;
    logic [7:0][7:0] exp_rows;

    rst_n             = 1'b0;
    bus.command       = '0;
    bus.x1            = '0;
    bus.y1            = '0;
    bus.x2            = '0;
    bus.y2            = '0;
    bus.rect_width    = '0;
    bus.rect_height   = '0;
    bus.command_valid = 1'b0;
    bus.rd_row        = '0;

    vecs[0] = '{cmd: CMD_PIXEL, x1: 3, y1: 5, x2: 0, y2: 0, w: 0, h: 0, edges: 2, rows: '0};
    vecs[0].rows[5] = 8'h08;
    vecs[1] = '{cmd: CMD_LINE, x1: 0, y1: 0, x2: 7, y2: 3, w: 5, h: 5, edges: 9, rows: '0};
    vecs[1].rows[0] = 8'h03;
    vecs[1].rows[1] = 8'h0C;
    vecs[1].rows[2] = 8'h30;
    vecs[1].rows[3] = 8'hC0;
    vecs[2] = '{cmd: CMD_RECT, x1: 6, y1: 6, x2: 0, y2: 0, w: 3, h: 3, edges: 5, rows: '0};
    vecs[2].rows[6] = 8'hC0;
    vecs[2].rows[7] = 8'hC0;
    vecs[3] = '{cmd: CMD_LINE, x1: 4, y1: 4, x2: 4, y2: 4, w: 0, h: 0, edges: 2, rows: '0};
    vecs[3].rows[4] = 8'h10;
    vecs[4] = '{cmd: CMD_LINE, x1: 5, y1: 7, x2: 2, y2: 0, w: 0, h: 0, edges: 9, rows: '0};
    vecs[4].rows[7] = 8'h20;
    vecs[4].rows[6] = 8'h20;
    vecs[4].rows[5] = 8'h10;
    vecs[4].rows[4] = 8'h10;
    vecs[4].rows[3] = 8'h08;
    vecs[4].rows[2] = 8'h08;
    vecs[4].rows[1] = 8'h04;
    vecs[4].rows[0] = 8'h04;
    vecs[5] = '{cmd: CMD_RECT, x1: 1, y1: 1, x2: 7, y2: 7, w: 2, h: 2, edges: 10, rows: '0};
    vecs[5].rows[1] = 8'h0E;
    vecs[5].rows[2] = 8'h0E;
    vecs[5].rows[3] = 8'h0E;
    vecs[6] = '{cmd: CMD_LINE, x1: 7, y1: 2, x2: 0, y2: 2, w: 0, h: 0, edges: 9, rows: '0};
    vecs[6].rows[2] = 8'hFF;

    // Reset state
    #12;
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_dropped", 64'(bus.cmd_dropped), 64'd0);
    check_rows("reset", '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table: clear, draw one command, check latency, pulse width and framebuffer
    for (int i = 0; i < 7; i++) begin
      issue(CMD_CLEAR, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
      wait_done(0, e);
      check($sformatf("v%0d_clear_edges", i), 64'(e), 64'd2);
      issue(vecs[i].cmd, vecs[i].x1, vecs[i].y1, vecs[i].x2, vecs[i].y2, vecs[i].w, vecs[i].h);
      check($sformatf("v%0d_busy", i), 64'(bus.busy), 64'd1);
      wait_done(0, e);
      check($sformatf("v%0d_edges", i), 64'(e), 64'(vecs[i].edges));
      check($sformatf("v%0d_busy_at_done", i), 64'(bus.busy), 64'd0);
      check_rows($sformatf("v%0d", i), vecs[i].rows);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_pulse", i), 64'(bus.done), 64'd0);
    end
    check("no_drop_yet", 64'(bus.cmd_dropped), 64'd0);

    // Command during a full-frame RECT is dropped; next command in done cycle accepted
    issue(CMD_CLEAR, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
    wait_done(0, e);
    issue(CMD_RECT, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd7);
    wait_done(10, e);
    check("full_rect_edges", 64'(e), 64'd65);
    check("dropped_set", 64'(bus.cmd_dropped), 64'd1);
    check_rows("full_rect", {8{8'hFF}});
    issue(CMD_CLEAR, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
    check("b2b_accept_busy", 64'(bus.busy), 64'd1);
    wait_done(0, e);
    check("b2b_clear_edges", 64'(e), 64'd2);
    check_rows("after_clear", '0);
    check("dropped_sticky", 64'(bus.cmd_dropped), 64'd1);

    // Async reset mid-LINE
    issue(CMD_LINE, 3'd0, 3'd0, 3'd7, 3'd3, 3'd0, 3'd0);
    repeat (3) @(posedge clk);
    #1;
    bus.rd_row = 3'd0;
    #0.2;
    check("midline_row0", 64'(bus.rd_data), 64'h03);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_dropped", 64'(bus.cmd_dropped), 64'd0);
    check_rows("abort", '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Same RECT drawn twice
    issue(CMD_RECT, 3'd1, 3'd1, 3'd0, 3'd0, 3'd2, 3'd2);
    wait_done(0, e);
    check("redraw1_edges", 64'(e), 64'd10);
    issue(CMD_RECT, 3'd1, 3'd1, 3'd0, 3'd0, 3'd2, 3'd2);
    wait_done(0, e);
    check("redraw2_edges", 64'(e), 64'd10);
    exp_rows = '0;
`ifndef RASTER_XOR_MODE_EN
    exp_rows[1] = 8'h0E;
    exp_rows[2] = 8'h0E;
    exp_rows[3] = 8'h0E;
`endif
    check_rows("redraw", exp_rows);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/raster_engine.md
Name: raster_engine

Overview:
- Drawing stage directly downstream of the command decoder.
- Consumes one decoded command (opcode, coordinates, rectangle size) on a single-cycle command_valid pulse.
- Rasterizes it into an internal 8x8 one-bit framebuffer at one pixel per clock.
- Exposes the framebuffer through a combinational row-read port for the display/output stage.

Parameters:
- COORD_W, 3, coordinate width; framebuffer is (2**COORD_W) x (2**COORD_W). Only the default 3 is required to work.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- command  input  2  opcode: 00 CLEAR, 01 PIXEL, 10 LINE, 11 RECT
- x1, y1  input  3 each  start point / rectangle origin
- x2, y2  input  3 each  line end point
- rect_width, rect_height  input  3 each  rectangle extent minus one (0 = one pixel)
- command_valid  input  1  one-cycle strobe; operands valid in the same cycle
- busy  output  1  high while a command is executing
- done  output  1  one-cycle pulse after the final write of a command
- cmd_dropped  output  1  sticky: a command_valid arrived while busy
- rd_row  input  3  framebuffer row select (y)
- rd_data  output  8  combinational row contents; bit x = pixel (x, rd_row)

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values:
  - all 64 framebuffer bits = 0
  - state = IDLE
  - busy = 0, done = 0, cmd_dropped = 0
  - all internal counters and latched operands = 0
- Reset asserted mid-command aborts the command immediately and clears the framebuffer.
- States: IDLE, CLEAR, PIXEL, LINE, RECT. busy = (state != IDLE), registered.
- Accept rule:
  - In IDLE, command_valid=1 at a clock edge latches all operands and moves to the state given by the opcode.
  - No framebuffer write occurs on the accept edge.
- done timing:
  - The edge that performs a command's last write returns to IDLE and sets done=1 for exactly one cycle.
  - A command_valid in that done cycle is accepted normally (back-to-back throughput).
- command_valid while busy: ignored; operands do not change; cmd_dropped <= 1, cleared only by reset.
- CLEAR: one edge zeroes all 64 bits. Latency: done high 2 edges after accept.
- PIXEL: one edge sets (x1,y1). Same latency as CLEAR.
- LINE:
  - Bresenham from (x1,y1) to (x2,y2), endpoints inclusive, one pixel per edge.
  - Write count = max(|x2-x1|, |y2-y1|) + 1.
  - dx = |x2-x1|, dy = -|y2-y1|, sx/sy = ±1; err initialised to dx+dy.
  - Each step: e2 = 2*err. If e2 >= dy: err += dy, x += sx. If e2 <= dx: err += dx, y += sy.
  - err and e2 are 6-bit signed. No step may leave 0..7.
  - A degenerate line (x1==x2, y1==y2) writes 1 pixel.
- RECT:
  - Filled rectangle, row-major: y outer, x inner.
  - Columns x1..xe, rows y1..ye, where xe = min(x1+rect_width, 7) and ye = min(y1+rect_height, 7).
  - Sums are computed at 4 bits before clipping, so there is no wrap-around.
  - Write count = (xe-x1+1)*(ye-y1+1).
- rd_data is purely combinational from the framebuffer. A write on edge N is visible after edge N.
- x2/y2 are ignored for RECT; rect_* are ignored for LINE.

Optional Feature:
- Macro: RASTER_XOR_MODE_EN.
- Defined: PIXEL, LINE and RECT toggle each target bit (fb ^= 1) instead of setting it. CLEAR is unchanged. Each pixel is written exactly once per command, so drawing the same shape twice restores the framebuffer.
- Undefined: writes OR in a 1. Redrawing is idempotent.

Decomposition:
- Package raster_pkg holds:
  - COORD_W
  - opcode constants CMD_CLEAR, CMD_PIXEL, CMD_LINE, CMD_RECT
  - the state encoding
  - the ERR_W=6 Bresenham error width
- One natural sub-module: raster_line_stepper.
  - Inputs: start/end points and a load/step handshake.
  - Outputs: current x, y and a last flag.
  - Holds the Bresenham registers.
- raster_engine owns the FSM, the RECT counters and the framebuffer.

Test Plan:
- Reset, then PIXEL (3,5) -> busy high 1 cycle; done 2 edges after accept; rd_row=5 gives rd_data=8'h08; all other rows 0.
- LINE (0,0)->(7,3) -> 8 writes, done 9 edges after accept. Rows 0..3 read 8'h03, 8'h0C, 8'h30, 8'hC0.
- RECT origin (6,6), w=3, h=3 -> clipped to 2x2, 4 writes. Rows 6 and 7 = 8'hC0; other rows 0; done 5 edges after accept.
- command_valid pulsed while a 64-pixel RECT (0,0,7,7) runs -> second command ignored, cmd_dropped=1, all rows 8'hFF. Next command_valid in the done cycle is accepted.
- CLEAR after a full frame -> all rows 0 after 1 write edge. rst_n dropped mid-LINE -> busy=0, done=0, framebuffer 0 asynchronously.
- With RASTER_XOR_MODE_EN: RECT (1,1,2,2) issued twice -> framebuffer all 0 after second done. Without the macro: rows 1..3 = 8'h0E.
